run_state_ctrl: RTL and testbench

//  Parametrised run/halt controller for the RV32I core with internal buffers.

---
 rtl/run_state_ctrl.sv | 133 +++++++++++++
 tb/tb_run_state_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_state_ctrl.sv
// Run/halt controller: gates core execution, stops on halt words, watchdog or abort,
// then holds done for a fixed number of cycles and requires start to be re-armed.
module run_state_ctrl #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] ECALL_WORD  = 32'h00000073,
  parameter logic [XLEN-1:0] EBREAK_WORD = 32'h00100073,
  parameter int              CNT_W       = 32,
  parameter int              TIMEOUT     = 0,
  parameter int              DONE_HOLD   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic             abort_in,
  input  logic             instr_valid,
  input  logic [XLEN-1:0]  instr_in,
  output logic             run_en,
  output logic             state_busy,
  output logic             state_done,
  output logic [2:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] C_NONE    = 3'd0;
  localparam logic [2:0] C_ECALL   = 3'd1;
  localparam logic [2:0] C_EBREAK  = 3'd2;
  localparam logic [2:0] C_TIMEOUT = 3'd3;
  localparam logic [2:0] C_ABORT   = 3'd4;

  localparam int              HOLD_W    = (DONE_HOLD < 2) ? 1 : $clog2(DONE_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DONE_HOLD - 1);
  localparam bit              TO_EN     = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST  = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Halt words packed low-to-high in cause order: ECALL, EBREAK.
  localparam logic [2*XLEN-1:0] HALT_WORDS = {EBREAK_WORD, ECALL_WORD};

  logic [1:0]        state_reg, state_next;
  logic              armed_reg, armed_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic [2:0]        cause_reg, cause_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              run_en_reg, busy_reg, done_reg;
  logic [1:0]        word_hit;
  logic              timeout_hit;
  logic [2:0]        hit_cause;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_word
      assign word_hit[gi] = instr_valid && (instr_in == HALT_WORDS[gi*XLEN +: XLEN]);
    end
  endgenerate

  assign timeout_hit = TO_EN && (count_reg == TO_LAST);

  always_comb begin
    hit_cause = C_NONE;
    if (abort_in)         hit_cause = C_ABORT;
    else if (word_hit[0]) hit_cause = C_ECALL;
    else if (word_hit[1]) hit_cause = C_EBREAK;
    else if (timeout_hit) hit_cause = C_TIMEOUT;
  end

  always_comb begin
    state_next = state_reg;
    armed_next = armed_reg;
    hold_next  = hold_reg;
    cause_next = cause_reg;
    count_next = count_reg;
    case (state_reg)
      S_IDLE: begin
        if (!start_in) begin
          armed_next = 1'b1;
        end else if (armed_reg) begin
          state_next = S_RUN;
          count_next = '0;
          cause_next = C_NONE;
        end
      end
      S_RUN: begin
        // The halting cycle itself is still counted.
        count_next = (count_reg == CNT_MAX) ? count_reg : count_reg + CNT_W'(1);
        if (hit_cause != C_NONE) begin
          state_next = S_DONE;
          cause_next = hit_cause;
          armed_next = 1'b0;
          hold_next  = '0;
        end
      end
      S_DONE: begin
        if (hold_reg == HOLD_LAST) state_next = S_IDLE;
        else                       hold_next  = hold_reg + HOLD_W'(1);
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      armed_reg  <= 1'b1;
      hold_reg   <= '0;
      cause_reg  <= C_NONE;
      count_reg  <= '0;
      run_en_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      armed_reg  <= armed_next;
      hold_reg   <= hold_next;
      cause_reg  <= cause_next;
      count_reg  <= count_next;
      // Status flags are decoded from the next state so they are true flops.
      run_en_reg <= (state_next == S_RUN);
      busy_reg   <= (state_next != S_IDLE);
      done_reg   <= (state_next == S_DONE);
    end
  end

  assign run_en      = run_en_reg;
  assign state_busy  = busy_reg;
  assign state_done  = done_reg;
  assign halt_cause  = cause_reg;
  assign cycle_count = count_reg;

endmodule

// File: tb/tb_run_state_ctrl.sv
// Bench for run_state_ctrl: two instances (watchdog off / hold 1, watchdog 8 / hold 4)
// driven by directed scenarios and a randomized run checked against a run-level model.
module tb_run_state_ctrl;

  localparam logic [31:0] ECALL  = 32'h00000073;
  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam int TO_P [2] = '{0, 8};
  localparam int DH_P [2] = '{1, 4};

  logic        clk = 1'b0;
  logic        rst, start, abort, valid;
  logic [31:0] instr;
  logic        ren [2];
  logic        bsy [2];
  logic        dn  [2];
  logic [2:0]  hc  [2];
  logic [31:0] cc  [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  run_state_ctrl #(.TIMEOUT(0), .DONE_HOLD(1)) dut_a (
    .clk(clk), .rst(rst), .start_in(start), .abort_in(abort), .instr_valid(valid),
    .instr_in(instr), .run_en(ren[0]), .state_busy(bsy[0]), .state_done(dn[0]),
    .halt_cause(hc[0]), .cycle_count(cc[0])
  );

  run_state_ctrl #(.TIMEOUT(8), .DONE_HOLD(4)) dut_b (
    .clk(clk), .rst(rst), .start_in(start), .abort_in(abort), .instr_valid(valid),
    .instr_in(instr), .run_en(ren[1]), .state_busy(bsy[1]), .state_done(dn[1]),
    .halt_cause(hc[1]), .cycle_count(cc[1])
  );

  // Run-level model: a run flag, a done countdown, and the latched cause/count.
  bit          m_run   [2];
  int          m_left  [2];
  bit          m_armed [2];
  logic [2:0]  m_cause [2];
  logic [31:0] m_cnt   [2];

  function automatic logic [2:0] halt_of(input int k);
    if (abort)                    return 3'd4;
    if (valid && instr == ECALL)  return 3'd1;
    if (valid && instr == EBREAK) return 3'd2;
    if (TO_P[k] != 0 && m_cnt[k] == 32'(TO_P[k] - 1)) return 3'd3;
    return 3'd0;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_run[k] <= 1'b0; m_left[k] <= 0; m_armed[k] <= 1'b1;
        m_cause[k] <= 3'd0; m_cnt[k] <= 32'd0;
      end else if (m_left[k] > 0) begin
        m_left[k] <= m_left[k] - 1;
      end else if (m_run[k]) begin
        m_cnt[k] <= (m_cnt[k] == 32'hFFFF_FFFF) ? m_cnt[k] : m_cnt[k] + 32'd1;
        if (halt_of(k) != 3'd0) begin
          m_run[k] <= 1'b0; m_left[k] <= DH_P[k];
          m_cause[k] <= halt_of(k); m_armed[k] <= 1'b0;
        end
      end else if (!start) begin
        m_armed[k] <= 1'b1;
      end else if (m_armed[k]) begin
        m_run[k] <= 1'b1; m_cnt[k] <= 32'd0; m_cause[k] <= 3'd0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_clear(input int n);
    start = 0; abort = 0; valid = 0; instr = 32'd0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1; start = 1; abort = 1; valid = 1; instr = ECALL;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({ren[k], bsy[k], dn[k], hc[k], cc[k]} !== 38'd0) begin
        n_bad++;
        $display("FAIL reset dut=%0d got run_en=%0b busy=%0b done=%0b cause=%0d count=%0d required all 0",
                 k, ren[k], bsy[k], dn[k], hc[k], cc[k]);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_ecall();
    rst = 1; start = 0; abort = 0; valid = 0; tick();
    rst = 0; start = 1; tick();
    for (int c = 1; c <= 7; c++) begin
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (ren[k] !== (c <= 5)) begin
          n_bad++; $display("FAIL t1_run_en dut=%0d c=%0d got %0b required %0b", k, c, ren[k], c <= 5);
        end
      end
      n_cmp++;
      if (dn[0] !== (c == 6)) begin
        n_bad++; $display("FAIL t1_done c=%0d got %0b required %0b", c, dn[0], c == 6);
      end
      if (c == 6) begin
        for (int k = 0; k < 2; k++) begin
          n_cmp++;
          if (hc[k] !== 3'd1 || cc[k] !== 32'd5) begin
            n_bad++; $display("FAIL t1_cause_count dut=%0d got %0d/%0d required 1/5", k, hc[k], cc[k]);
          end
        end
      end
      valid = (c == 5); instr = ECALL;
      tick();
    end
    idle_clear(6);
    $display("test_ecall done");
  endtask

  task automatic test_ebreak_valid();
    start = 1; tick();
    instr = EBREAK; valid = 0; tick(); tick();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (ren[k] !== 1'b1) begin
        n_bad++; $display("FAIL t2_ignored dut=%0d got run_en=%0b required 1", k, ren[k]);
      end
    end
    valid = 1; tick();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (dn[k] !== 1'b1 || hc[k] !== 3'd2 || cc[k] !== 32'd3) begin
        n_bad++; $display("FAIL t2_halt dut=%0d got done=%0b cause=%0d count=%0d required 1/2/3", k, dn[k], hc[k], cc[k]);
      end
    end
    idle_clear(6);
    $display("test_ebreak_valid done");
  endtask

  task automatic test_timeout();
    int rb = 0;
    int db = 0;
    start = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ren[1]) rb++;
      if (dn[1])  db++;
    end
    n_cmp++;
    if (rb != 8 || db != 4) begin
      n_bad++; $display("FAIL t3_widths got run=%0d done=%0d required 8/4", rb, db);
    end
    n_cmp++;
    if (hc[1] !== 3'd3 || cc[1] !== 32'd8) begin
      n_bad++; $display("FAIL t3_cause_count got %0d/%0d required 3/8", hc[1], cc[1]);
    end
    abort = 1; tick(); abort = 0;
    n_cmp++;
    if (hc[0] !== 3'd4 || cc[0] !== 32'd20 || hc[1] !== 3'd3) begin
      n_bad++; $display("FAIL t3_abort_a got a=%0d/%0d b=%0d required 4/20 b=3", hc[0], cc[0], hc[1]);
    end
    idle_clear(6);
    $display("test_timeout done");
  endtask

  task automatic test_abort_priority();
    start = 1; tick(); tick(); tick();
    abort = 1; valid = 1; instr = ECALL; tick();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (hc[k] !== 3'd4 || dn[k] !== 1'b1 || cc[k] !== 32'd3) begin
        n_bad++; $display("FAIL t4_priority dut=%0d got cause=%0d done=%0b count=%0d required 4/1/3", k, hc[k], dn[k], cc[k]);
      end
    end
    idle_clear(6);
    $display("test_abort_priority done");
  endtask

  task automatic test_back_to_back();
    start = 1; tick(); tick();
    valid = 1; instr = ECALL; tick();
    valid = 0;
    repeat (10) tick();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (ren[k] !== 1'b0 || bsy[k] !== 1'b0 || hc[k] !== 3'd1 || cc[k] !== 32'd2) begin
        n_bad++; $display("FAIL t5_hold dut=%0d got run_en=%0b busy=%0b cause=%0d count=%0d required 0/0/1/2",
                          k, ren[k], bsy[k], hc[k], cc[k]);
      end
    end
    start = 0; tick();
    start = 1; tick();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (ren[k] !== 1'b1 || hc[k] !== 3'd0 || cc[k] !== 32'd0) begin
        n_bad++; $display("FAIL t5_rearm dut=%0d got run_en=%0b cause=%0d count=%0d required 1/0/0", k, ren[k], hc[k], cc[k]);
      end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    tick(); tick();
    rst = 1; tick(); rst = 0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({ren[k], bsy[k], dn[k], hc[k], cc[k]} !== 38'd0) begin
        n_bad++; $display("FAIL t6_mid_run dut=%0d got run_en=%0b busy=%0b count=%0d required 0", k, ren[k], bsy[k], cc[k]);
      end
    end
    tick();
    valid = 1; instr = ECALL; tick(); valid = 0;
    tick();
    n_cmp++;
    if (dn[1] !== 1'b1) begin
      n_bad++; $display("FAIL t6_in_done got done=%0b required 1", dn[1]);
    end
    rst = 1; tick(); rst = 0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({ren[k], bsy[k], dn[k], hc[k], cc[k]} !== 38'd0) begin
        n_bad++; $display("FAIL t6_mid_done dut=%0d got busy=%0b done=%0b cause=%0d required 0", k, bsy[k], dn[k], hc[k]);
      end
    end
    idle_clear(6);
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    int bad_before = n_bad;
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(299) == 0);
      start = ($urandom_range(3) != 0);
      abort = ($urandom_range(39) == 0);
      valid = ($urandom_range(2) == 0);
      case ($urandom_range(19))
        0:       instr = ECALL;
        1:       instr = EBREAK;
        default: instr = $urandom;
      endcase
      tick();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (ren[k] !== m_run[k] || dn[k] !== (m_left[k] > 0) || bsy[k] !== (m_run[k] || m_left[k] > 0) ||
            hc[k] !== m_cause[k] || cc[k] !== m_cnt[k]) begin
          n_bad++;
          $display("FAIL random dut=%0d cyc=%0d got en=%0b done=%0b busy=%0b cause=%0d cnt=%0d required en=%0b done=%0b busy=%0b cause=%0d cnt=%0d",
                   k, i, ren[k], dn[k], bsy[k], hc[k], cc[k],
                   m_run[k], m_left[k] > 0, m_run[k] || m_left[k] > 0, m_cause[k], m_cnt[k]);
        end
      end
    end
    $display("test_random done, %0d new discrepancies", n_bad - bad_before);
  endtask

  initial begin
    rst = 1; start = 0; abort = 0; valid = 0; instr = 32'd0;
    @(negedge clk);
    test_reset();
    test_ecall();
    test_ebreak_valid();
    test_timeout();
    test_abort_priority();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
